mem_stage_lsu: RTL and testbench

Parametrised memory stage for the pipelined core: the M-to-W pipeline register with an integrated word-organised data memory. It adds RV32 sub-word loads and stores (byte/half/word, sign/zero extension), a configurable data-memory latency with a stall handshake back to earlier stages, and bubble insertion into W while an access is in flight. It sits between the execute-stage register and writeback.

---
 rtl/mem_stage_lsu.sv | 182 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// M-to-W pipeline register with integrated word-organised data memory, RV32 sub-word
// loads/stores and a LAT-cycle access stall. Optional macro: MEM_MISALIGN_TRAP_EN.
module mem_stage_lsu #(
  parameter int XLEN      = 32,
  parameter int RD_W_BITS = 5,
  parameter int DEPTH     = 1024,
  parameter int LAT       = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RegWriteM,
  input  logic                 MemReadM,
  input  logic                 MemWriteM,
  input  logic [1:0]           ResultSrcM,
  input  logic [2:0]           Funct3M,
  input  logic [RD_W_BITS-1:0] RD_M,
  input  logic [XLEN-1:0]      PCPlus4M,
  input  logic [XLEN-1:0]      WriteDataM,
  input  logic [XLEN-1:0]      ALU_ResultM,
  output logic                 StallM,
  output logic                 RegWriteW,
  output logic [1:0]           ResultSrcW,
  output logic [RD_W_BITS-1:0] RD_W,
  output logic [XLEN-1:0]      PCPlus4W,
  output logic [XLEN-1:0]      ALU_ResultW,
  output logic [XLEN-1:0]      ReadDataW,
  output logic                 MisalignW
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (LAT > 0) ? CW'(LAT - 1) : '0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          stall, complete;

  logic            mem_req, is_load, misalign, mem_we;
  logic [1:0]      size, lane, eff_lane;
  logic [AW-1:0]   word_idx;
  logic [3:0]      byte_en;
  logic [XLEN-1:0] wr_data, rd_word, load_data;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;

  logic [XLEN-1:0] mem [DEPTH];

  assign mem_req  = MemReadM | MemWriteM;
  assign is_load  = MemReadM & ~MemWriteM;
  assign size     = Funct3M[1:0];
  assign lane     = ALU_ResultM[1:0];
  assign word_idx = ALU_ResultM[AW+1:2];

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = mem_req & (((size == 2'b01) & lane[0]) | ((size == 2'b10) & (lane != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // Address bits below the access size are ignored; with the trap enabled they only raise misalign.
  always_comb begin
    case (size)
      2'b01:   eff_lane = {lane[1], 1'b0};
      2'b10:   eff_lane = 2'b00;
      default: eff_lane = lane;
    endcase
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    byte_en = 4'b1111;
    wr_data = WriteDataM;
    case (size)
      2'b00: begin
        byte_en = 4'b0001 << eff_lane;
        wr_data = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        byte_en = 4'b0011 << eff_lane;
        wr_data = {2{WriteDataM[15:0]}};
      end
      default: ;
    endcase
  end

  assign rd_word = mem[word_idx];
  assign rd_byte = rd_word[{eff_lane, 3'b000} +: 8];
  assign rd_half = rd_word[{eff_lane[1], 4'b0000} +: 16];

  always_comb begin
    case (size)
      2'b00:   load_data = Funct3M[2] ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_data = Funct3M[2] ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_data = rd_word;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall    = 1'b0;
    complete = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          if (LAT == 0) begin
            complete = 1'b1;
          end else begin
            stall    = 1'b1;
            state_nx = BUSY;
            cnt_nx   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          stall  = 1'b1;
          cnt_nx = cnt - 1'b1;
        end else begin
          complete = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign StallM = stall;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  assign mem_we = rst & complete & MemWriteM & ~misalign;

  // NOTE: the data array has no reset; clearing it would need a per-word reset network.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 2'b00;
      RD_W        <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
      MisalignW   <= 1'b0;
    end else if (stall) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 2'b00;
      RD_W        <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
      MisalignW   <= 1'b0;
    end else begin
      RegWriteW   <= RegWriteM & ~misalign;
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      PCPlus4W    <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= (is_load & ~misalign) ? load_data : '0;
      MisalignW   <= misalign;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a LAT=0 and a LAT=3 instance share one input bus.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemReadM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

  logic        s0, rw0, mis0, s3, rw3, mis3;
  logic [1:0]  rs0, rs3;
  logic [4:0]  rd0, rd3;
  logic [31:0] pc0, alu0, dat0, pc3, alu3, dat3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.LAT(0)) u_lat0 (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
    .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM), .StallM(s0), .RegWriteW(rw0),
    .ResultSrcW(rs0), .RD_W(rd0), .PCPlus4W(pc0), .ALU_ResultW(alu0), .ReadDataW(dat0),
    .MisalignW(mis0)
  );

  mem_stage_lsu #(.LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
    .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM), .StallM(s3), .RegWriteW(rw3),
    .ResultSrcW(rs3), .RD_W(rd3), .PCPlus4W(pc3), .ALU_ResultW(alu3), .ReadDataW(dat3),
    .MisalignW(mis3)
  );

  typedef struct {
    string       name;
    logic        we, re, rw;
    logic [2:0]  f3;
    logic [31:0] addr, wd;
    logic [4:0]  rd;
    logic [31:0] exp_data;
    logic        exp_rw, exp_mis;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic re, input logic rw, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] pc4);
    MemWriteM   = we;
    MemReadM    = re;
    RegWriteM   = rw;
    ResultSrcM  = (re && !we) ? 2'b01 : 2'b00;
    Funct3M     = f3;
    ALU_ResultM = addr;
    WriteDataM  = wd;
    RD_M        = rd;
    PCPlus4M    = pc4;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 5'd0, 32'h0);
  endtask

  function automatic vec_t mk(input string name, input logic we, input logic re, input logic rw,
                              input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [4:0] rd, input logic [31:0] exp_data,
                              input logic exp_rw, input logic exp_mis);
    vec_t v;
    v.name = name; v.we = we; v.re = re; v.rw = rw; v.f3 = f3; v.addr = addr; v.wd = wd;
    v.rd = rd; v.exp_data = exp_data; v.exp_rw = exp_rw; v.exp_mis = exp_mis;
    return v;
  endfunction

  // LAT=3 access: stall in the presenting cycle and two more, three bubbles, completion on edge 4.
  task automatic lat3_op(input string name, input logic we, input logic re, input logic rw,
                         input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] exp_data, input logic exp_rw);
    drive(we, re, rw, f3, addr, wd, rd, 32'h2000);
    #1;
    check({name, " stall_t"}, {31'b0, s3}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check({name, " bubble_rw"}, {31'b0, rw3}, 32'd0);
      check({name, " bubble_rd"}, {27'b0, rd3}, 32'd0);
      check({name, " stall"}, {31'b0, s3}, (k < 2) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    check({name, " data"}, dat3, exp_data);
    check({name, " rw"}, {31'b0, rw3}, {31'b0, exp_rw});
    check({name, " rd"}, {27'b0, rd3}, {27'b0, rd});
  endtask

  initial begin
`ifdef MEM_MISALIGN_TRAP_EN
    localparam logic        MIS_EXP  = 1'b1;
    localparam logic        MIS_RW   = 1'b0;
    localparam logic [31:0] WORD_20  = 32'h11223344;
`else
    localparam logic        MIS_EXP  = 1'b0;
    localparam logic        MIS_RW   = 1'b1;
    localparam logic [31:0] WORD_20  = 32'h1122BEEF;
`endif
    tbl.push_back(mk("sw_10",     1, 0, 0, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0, 32'h0, 0, 0));
    tbl.push_back(mk("lw_10",     0, 1, 1, 3'b010, 32'h10, 32'h0, 5'd5, 32'hDEADBEEF, 1, 0));
    tbl.push_back(mk("lb_13",     0, 1, 1, 3'b000, 32'h13, 32'h0, 5'd6, 32'hFFFFFFDE, 1, 0));
    tbl.push_back(mk("lbu_13",    0, 1, 1, 3'b100, 32'h13, 32'h0, 5'd7, 32'h000000DE, 1, 0));
    tbl.push_back(mk("lh_12",     0, 1, 1, 3'b001, 32'h12, 32'h0, 5'd8, 32'hFFFFDEAD, 1, 0));
    tbl.push_back(mk("lhu_10",    0, 1, 1, 3'b101, 32'h10, 32'h0, 5'd9, 32'h0000BEEF, 1, 0));
    tbl.push_back(mk("sb_11",     1, 0, 0, 3'b000, 32'h11, 32'h00000055, 5'd0, 32'h0, 0, 0));
    tbl.push_back(mk("lw_after_sb", 0, 1, 1, 3'b010, 32'h10, 32'h0, 5'd10, 32'hDEAD55EF, 1, 0));
    tbl.push_back(mk("sh_12",     1, 0, 0, 3'b001, 32'h12, 32'hAAAA1234, 5'd0, 32'h0, 0, 0));
    tbl.push_back(mk("lw_after_sh", 0, 1, 1, 3'b010, 32'h10, 32'h0, 5'd11, 32'h123455EF, 1, 0));
    tbl.push_back(mk("alu_op",    0, 0, 1, 3'b000, 32'h777, 32'h0, 5'd12, 32'h0, 1, 0));
    tbl.push_back(mk("lb_10",     0, 1, 1, 3'b000, 32'h10, 32'h0, 5'd13, 32'hFFFFFFEF, 1, 0));
    tbl.push_back(mk("lh_alias",  0, 1, 1, 3'b001, 32'h10000010, 32'h0, 5'd14, 32'h000055EF, 1, 0));
    tbl.push_back(mk("rd_and_wr", 1, 1, 1, 3'b010, 32'h30, 32'hCAFEF00D, 5'd15, 32'h0, 1, 0));
    tbl.push_back(mk("lw_30",     0, 1, 1, 3'b010, 32'h30, 32'h0, 5'd16, 32'hCAFEF00D, 1, 0));
    tbl.push_back(mk("sw_20",     1, 0, 0, 3'b010, 32'h20, 32'h11223344, 5'd0, 32'h0, 0, 0));
    tbl.push_back(mk("sh_21",     1, 0, 1, 3'b001, 32'h21, 32'h0000BEEF, 5'd17, 32'h0, MIS_RW, MIS_EXP));
    tbl.push_back(mk("lw_20",     0, 1, 1, 3'b010, 32'h20, 32'h0, 5'd18, WORD_20, 1, 0));

    rst = 1'b0;
    drive_idle();
    #3;
    check("rst rw0", {31'b0, rw0}, 32'd0);
    check("rst data0", dat0, 32'h0);
    check("rst stall3", {31'b0, s3}, 32'd0);
    check("rst alu3", alu3, 32'h0);
    #9 rst = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      drive(tbl[i].we, tbl[i].re, tbl[i].rw, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].rd,
            32'h1000 + 32'(4 * i));
      #1;
      check({tbl[i].name, " stall"}, {31'b0, s0}, 32'd0);
      @(posedge clk); #1;
      check({tbl[i].name, " data"}, dat0, tbl[i].exp_data);
      check({tbl[i].name, " rw"}, {31'b0, rw0}, {31'b0, tbl[i].exp_rw});
      check({tbl[i].name, " rd"}, {27'b0, rd0}, {27'b0, tbl[i].rd});
      check({tbl[i].name, " mis"}, {31'b0, mis0}, {31'b0, tbl[i].exp_mis});
      check({tbl[i].name, " pc4"}, pc0, 32'h1000 + 32'(4 * i));
    end

    // Asynchronous reset mid-cycle clears W at once.
    drive(1'b0, 1'b0, 1'b1, 3'b000, 32'h55, 32'h0, 5'd3, 32'h44);
    @(posedge clk); #1;
    check("pre_rst rw0", {31'b0, rw0}, 32'd1);
    #1 rst = 1'b0;
    drive_idle();
    #1;
    check("mid_rst rw0", {31'b0, rw0}, 32'd0);
    check("mid_rst rd0", {27'b0, rd0}, 32'd0);
    check("mid_rst alu0", alu0, 32'h0);
    check("mid_rst pc0", pc0, 32'h0);
    check("mid_rst rs0", {30'b0, rs0}, 32'd0);
    check("mid_rst stall0", {31'b0, s0}, 32'd0);
    check("mid_rst stall3", {31'b0, s3}, 32'd0);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    lat3_op("l3_sw", 1, 0, 0, 3'b010, 32'h100, 32'hA5A50001, 5'd0, 32'h0, 0);
    lat3_op("l3_lw_a", 0, 1, 1, 3'b010, 32'h100, 32'h0, 5'd7, 32'hA5A50001, 1);
    lat3_op("l3_lw_b", 0, 1, 1, 3'b000, 32'h100, 32'h0, 5'd8, 32'h00000001, 1);

    // Store aborted by a reset while BUSY must never reach memory.
    drive(1'b1, 1'b0, 1'b0, 3'b010, 32'h100, 32'hFFFF0000, 5'd0, 32'h0);
    @(posedge clk); #1;
    check("l3_abort busy", {31'b0, s3}, 32'd1);
    rst = 1'b0;
    #1 drive_idle();
    #1;
    check("l3_abort stall", {31'b0, s3}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    lat3_op("l3_lw_old", 0, 1, 1, 3'b010, 32'h100, 32'h0, 5'd9, 32'hA5A50001, 1);

    drive_idle();
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
